// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
package hazard_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ld;
        logic              v;
    } stage_tag_t;

    // XZR writes are discarded, so they never produce a value worth forwarding.
    function automatic logic is_writer(stage_tag_t t);
        return t.v & t.we & (t.rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side request and EX-side forwarding/stall response of the hazard controller.
interface fwd_hazard_ctrl_if;

    logic                             id_valid;
    logic [hazard_pkg::ADDR_W-1:0]    id_rn;
    logic [hazard_pkg::ADDR_W-1:0]    id_rm;
    logic                             id_use_rn;
    logic                             id_use_rm;
    logic [hazard_pkg::ADDR_W-1:0]    id_rd;
    logic                             id_reg_write;
    logic                             id_mem_read;
    logic                             flush;
    logic                             stall;
    logic [1:0]                       ex_fwd_a;
    logic [1:0]                       ex_fwd_b;
    logic                             ex_bubble;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write,
               id_mem_read, flush,
        input  stall, ex_fwd_a, ex_fwd_b, ex_bubble
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write,
               id_mem_read, flush,
        output stall, ex_fwd_a, ex_fwd_b, ex_bubble
    );

endinterface

// File: rtl/tag_match.sv
// Resolves one decode source against the one-ahead and two-ahead producer tags.
module tag_match
    import hazard_pkg::*;
(
    input  logic [ADDR_W-1:0] src_i,
    input  logic              use_i,
    input  stage_tag_t        ex_tag_i,
    input  stage_tag_t        mem_tag_i,
    output fwd_sel_t          sel_o,
    output logic              ld_hit_o
);

    logic src_ok;
    logic ex_hit;
    logic mem_hit;
    logic unused_mem_ld;

    assign src_ok   = use_i & (src_i != ZERO_REG);
    assign ex_hit   = src_ok & is_writer(ex_tag_i) & (ex_tag_i.rd == src_i);
    assign mem_hit  = src_ok & is_writer(mem_tag_i) & (mem_tag_i.rd == src_i);
    assign ld_hit_o = ex_hit & ex_tag_i.ld;

    // A load two ahead has its data by MEM/WB, so only the one-ahead load matters.
    assign unused_mem_ld = mem_tag_i.ld;

    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit) begin
            sel_o = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Shadow tag pipeline with registered forwarding selects and a combinational load-use stall.
module fwd_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    fwd_hazard_ctrl_if.slave        bus
);

    stage_tag_t ex_tag_q, ex_tag_d;
    stage_tag_t mem_tag_q;
    stage_tag_t wb_tag_q;
    fwd_sel_t   ex_fwd_a_q, ex_fwd_a_d;
    fwd_sel_t   ex_fwd_b_q, ex_fwd_b_d;
    logic       ex_bubble_q, ex_bubble_d;

    fwd_sel_t   sel_a;
    fwd_sel_t   sel_b;
    logic       ld_hit_a;
    logic       ld_hit_b;
    logic       stall;
    logic       issue;
    logic       unused_wb;

    tag_match u_match_rn (
        .src_i     (bus.id_rn),
        .use_i     (bus.id_use_rn),
        .ex_tag_i  (ex_tag_q),
        .mem_tag_i (mem_tag_q),
        .sel_o     (sel_a),
        .ld_hit_o  (ld_hit_a)
    );

    tag_match u_match_rm (
        .src_i     (bus.id_rm),
        .use_i     (bus.id_use_rm),
        .ex_tag_i  (ex_tag_q),
        .mem_tag_i (mem_tag_q),
        .sel_o     (sel_b),
        .ld_hit_o  (ld_hit_b)
    );

    assign stall = bus.id_valid & ~bus.flush & (ld_hit_a | ld_hit_b);
    assign issue = bus.id_valid & ~bus.flush & ~stall;

    always_comb begin
        ex_tag_d    = '0;
        ex_fwd_a_d  = FWD_RF;
        ex_fwd_b_d  = FWD_RF;
        ex_bubble_d = 1'b1;
        if (issue) begin
            ex_tag_d    = '{rd: bus.id_rd, we: bus.id_reg_write, ld: bus.id_mem_read, v: 1'b1};
            ex_fwd_a_d  = sel_a;
            ex_fwd_b_d  = sel_b;
            ex_bubble_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_tag_q    <= '0;
            mem_tag_q   <= '0;
            wb_tag_q    <= '0;
            ex_fwd_a_q  <= FWD_RF;
            ex_fwd_b_q  <= FWD_RF;
            ex_bubble_q <= 1'b1;
        end else begin
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= ex_tag_q;
            wb_tag_q    <= mem_tag_q;
            ex_fwd_a_q  <= ex_fwd_a_d;
            ex_fwd_b_q  <= ex_fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    // WB results reach readers through the write-first register file, not a bypass.
    assign unused_wb = ^wb_tag_q;

    assign bus.stall     = stall;
    assign bus.ex_fwd_a  = ex_fwd_a_q;
    assign bus.ex_fwd_b  = ex_fwd_b_q;
    assign bus.ex_bubble = ex_bubble_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and randomized checks of fwd_hazard_ctrl against an instruction-history model.
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rn;
        bit [4:0] rm;
        bit       use_rn;
        bit       use_rm;
        bit       we;
        bit       ld;
    } ins_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    // Instructions that entered EX one and two cycles ago (v = 0 for bubbles).
    ins_t ahead1 = '0;
    ins_t ahead2 = '0;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(bit [4:0] rd, bit [4:0] rn, bit [4:0] rm, bit urn, bit urm,
                                bit we, bit ld);
        ins_t r;
        r.v = 1'b1; r.rd = rd; r.rn = rn; r.rm = rm;
        r.use_rn = urn; r.use_rm = urm; r.we = we; r.ld = ld;
        return r;
    endfunction

    // Does older instruction p produce the value that source s of a later reader needs?
    function automatic bit produces(ins_t p, bit [4:0] s, bit use_s);
        return use_s && s != 5'd31 && p.v && p.we && p.rd != 5'd31 && p.rd == s;
    endfunction

    function automatic int fwd_for(bit [4:0] s, bit use_s);
        if (produces(ahead1, s, use_s)) return 1;
        if (produces(ahead2, s, use_s)) return 2;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t i, input bit fl);
        bus.id_valid     = i.v;
        bus.id_rd        = i.rd;
        bus.id_rn        = i.rn;
        bus.id_rm        = i.rm;
        bus.id_use_rn    = i.use_rn;
        bus.id_use_rm    = i.use_rm;
        bus.id_reg_write = i.we;
        bus.id_mem_read  = i.ld;
        bus.flush        = fl;
    endtask

    // One cycle from a negedge to the next; reports whether the model expected a stall.
    task automatic step(input string tag, input ins_t i, input bit fl, output bit stalled);
        bit exp_stall;
        bit take;
        int exp_a;
        int exp_b;
        drive(i, fl);
        #1;
        exp_stall = i.v && !fl && ahead1.ld &&
                    (produces(ahead1, i.rn, i.use_rn) || produces(ahead1, i.rm, i.use_rm));
        check({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        take  = i.v && !fl && !exp_stall;
        exp_a = take ? fwd_for(i.rn, i.use_rn) : 0;
        exp_b = take ? fwd_for(i.rm, i.use_rm) : 0;
        @(posedge clk);
        #1;
        check({tag, ".fwd_a"}, 32'(bus.ex_fwd_a), exp_a);
        check({tag, ".fwd_b"}, 32'(bus.ex_fwd_b), exp_b);
        check({tag, ".bubble"}, 32'(bus.ex_bubble), 32'(!take));
        ahead2 = ahead1;
        ahead1 = take ? i : '0;
        stalled = exp_stall;
        @(negedge clk);
    endtask

    initial begin
        bit   st;
        ins_t nop;
        ins_t cur;
        nop = mk(5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state with a valid reader presented.
        drive(mk(5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        @(negedge clk);
        check("rst.stall", 32'(bus.stall), 0);
        check("rst.fwd_a", 32'(bus.ex_fwd_a), 0);
        check("rst.fwd_b", 32'(bus.ex_fwd_b), 0);
        check("rst.bubble", 32'(bus.ex_bubble), 1);
        reset = 1'b0;

        // ADD X1 ; SUB X2,X1,X3
        step("add1", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("sub", mk(5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        check("sub.fwd_a_is_1", 32'(bus.ex_fwd_a), 1);
        // ADD X1 ; NOP ; ORR X4,X5,X1
        step("add1b", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("nop", nop, 1'b0, st);
        step("orr", mk(5'd4, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        check("orr.fwd_b_is_2", 32'(bus.ex_fwd_b), 2);
        // LDUR X7 ; ADD X8,X7,X7 -> one stall then MEM/WB forwarding
        step("ldur", mk(5'd7, 5'd9, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, st);
        cur = mk(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        step("lu1", cur, 1'b0, st);
        check("lu1.stalled", 32'(st), 1);
        step("lu2", cur, 1'b0, st);
        check("lu2.fwd_a_is_2", 32'(bus.ex_fwd_a), 2);
        // XZR never forwards or stalls
        step("add31", mk(5'd31, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("rd31", mk(5'd2, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("ld31", mk(5'd31, 5'd9, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, st);
        step("use31", mk(5'd3, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        // Newer producer wins
        step("addx1", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("movx1", mk(5'd1, 5'd31, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("rdx1", mk(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        check("rdx1.newer", 32'(bus.ex_fwd_a), 1);
        // Flush beats load-use stall
        step("ldur2", mk(5'd7, 5'd9, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, st);
        step("flush", mk(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, st);
        check("flush.bubble_is_1", 32'(bus.ex_bubble), 1);
        // Reset with writers in flight
        step("w1", mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        step("w2", mk(5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);
        drive(mk(5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        reset = 1'b1;
        #1;
        check("midrst.fwd_a", 32'(bus.ex_fwd_a), 0);
        check("midrst.fwd_b", 32'(bus.ex_fwd_b), 0);
        check("midrst.bubble", 32'(bus.ex_bubble), 1);
        check("midrst.stall", 32'(bus.stall), 0);
        @(negedge clk);
        reset = 1'b0;
        ahead1 = '0;
        ahead2 = '0;
        step("postrst", mk(5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, st);

        // Random traffic over a small register set so hazards are frequent.
        cur = nop;
        st = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit fl;
            if (!st) begin
                cur.v      = ($urandom_range(0, 9) != 0);
                cur.rd     = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
                cur.rn     = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
                cur.rm     = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
                cur.use_rn = ($urandom_range(0, 3) != 0);
                cur.use_rm = ($urandom_range(0, 1) != 0);
                cur.ld     = ($urandom_range(0, 2) == 0);
                cur.we     = cur.ld || ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            step("rand", cur, fl, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
